// File: rtl/axis_hdr_insert_pkg.sv
// Shared state encoding and keep helpers for axis_hdr_insert_v2.
package axis_hdr_insert_pkg;

  typedef enum logic [1:0] {IDLE, HDR, BODY, TAIL} state_t;

  // Width for header beat count, residual byte count and tail byte count.
  localparam int CNT_WD = 8;

  function automatic int unsigned popcnt(input logic [63:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 64; i++) n = n + 32'(v[i]);
    return n;
  endfunction

  // n most-significant bits of a w-bit keep set.
  function automatic logic [63:0] hi_keep(input int unsigned n, input int unsigned w);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 64; i++)
      if (i < int'(w) && i >= int'(w) - int'(n)) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-entry valid/ready output register; push only when free, contents hold while stalled.
module axis_out_reg #(
  parameter int DATA_WD = 32,
  parameter int KEEP_WD = DATA_WD/8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [DATA_WD-1:0] push_data,
  input  logic [KEEP_WD-1:0] push_keep,
  input  logic               push_last,
  output logic               free,
  output logic               valid,
  output logic [DATA_WD-1:0] data,
  output logic [KEEP_WD-1:0] keep,
  output logic               last,
  input  logic               ready
);

  assign free = !valid || ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      keep  <= '0;
      last  <= 1'b0;
    end else if (push) begin
      valid <= 1'b1;
      data  <= push_data;
      keep  <= push_keep;
      last  <= push_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_hdr_insert_v2.sv
// Prepends a 0..HDR_MAX_BYTES byte header to each AXI-Stream packet and repacks the payload gap-free.
// AXIS_INS_STAT_EN adds pkt_cnt/byte_cnt output-handshake counters.
module axis_hdr_insert_v2
  import axis_hdr_insert_pkg::*;
#(
  parameter int DATA_WD       = 32,
  parameter int DATA_BYTE_WD  = DATA_WD/8,
  parameter int HDR_MAX_BYTES = 8,
  parameter int HCNT_WD       = $clog2(HDR_MAX_BYTES+1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_insert,
  input  logic [8*HDR_MAX_BYTES-1:0] data_insert,
  input  logic [HDR_MAX_BYTES-1:0]   keep_insert,
  input  logic [HCNT_WD-1:0]         byte_insert_cnt,
  output logic                       ready_insert,
  input  logic                       valid_in,
  output logic                       ready_in,
  input  logic [DATA_WD-1:0]         data_in,
  input  logic [DATA_BYTE_WD-1:0]    keep_in,
  input  logic                       last_in,
  output logic                       valid_out,
  input  logic                       ready_out,
  output logic [DATA_WD-1:0]         data_out,
  output logic [DATA_BYTE_WD-1:0]    keep_out,
  output logic                       last_out
`ifdef AXIS_INS_STAT_EN
  ,
  output logic [31:0]                pkt_cnt,
  output logic [47:0]                byte_cnt
`endif
);

  localparam int HW    = 8*HDR_MAX_BYTES;
  localparam int SR_WD = (HW > DATA_WD) ? HW : DATA_WD;
  localparam logic [CNT_WD-1:0] WB       = CNT_WD'(DATA_BYTE_WD);
  localparam logic [CNT_WD-1:0] SR_BYTES = CNT_WD'(SR_WD/8);

  state_t              state;
  logic [SR_WD-1:0]    hdr_sr, hdr_al, hdr_next;
  logic [DATA_WD-1:0]  carry, merged;
  logic [CNT_WD-1:0]   beats, res, tail_n, h_cl, k_in;
  logic                ins_rdy, free, push, push_last, in_hs, ins_hs, fits;
  logic [DATA_WD-1:0]  push_data;
  logic [DATA_BYTE_WD-1:0] push_keep;
  logic                unused_keep_insert;

  assign unused_keep_insert = ^keep_insert;
  assign ready_insert = ins_rdy;
  assign ready_in     = (state == BODY) && free;
  assign in_hs        = valid_in && ready_in;
  assign ins_hs       = valid_insert && ins_rdy;

  always_comb begin
    h_cl = (byte_insert_cnt > HCNT_WD'(HDR_MAX_BYTES)) ? CNT_WD'(HDR_MAX_BYTES)
                                                        : CNT_WD'(byte_insert_cnt);
    // Left-align the header so its first byte sits at the MSB of the shift register.
    hdr_al   = SR_WD'(data_insert) << {SR_BYTES - h_cl, 3'b000};
    hdr_next = hdr_sr << DATA_WD;
    k_in     = CNT_WD'(popcnt(64'(keep_in)));
    fits     = (k_in + res) <= WB;
    merged   = (res == '0) ? data_in : (carry | (data_in >> {res, 3'b000}));

    push      = 1'b0;
    push_data = '0;
    push_keep = '0;
    push_last = 1'b0;
    unique case (state)
      IDLE: ;
      HDR: begin
        push      = free;
        push_data = hdr_sr[SR_WD-1 -: DATA_WD];
        push_keep = '1;
      end
      BODY: begin
        push      = in_hs;
        push_data = merged;
        push_keep = '1;
        if (last_in && fits) begin
          push_last = 1'b1;
          push_keep = (res == '0) ? keep_in
                    : DATA_BYTE_WD'(hi_keep(32'(res) + 32'(k_in), DATA_BYTE_WD));
        end
      end
      TAIL: begin
        push      = free;
        push_data = carry;
        push_keep = DATA_BYTE_WD'(hi_keep(32'(tail_n), DATA_BYTE_WD));
        push_last = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      hdr_sr  <= '0;
      carry   <= '0;
      beats   <= '0;
      res     <= '0;
      tail_n  <= '0;
      ins_rdy <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          ins_rdy <= 1'b1;
          if (ins_hs) begin
            ins_rdy <= 1'b0;
            hdr_sr  <= hdr_al;
            carry   <= hdr_al[SR_WD-1 -: DATA_WD];
            beats   <= h_cl / WB;
            res     <= h_cl % WB;
            state   <= (h_cl >= WB) ? HDR : BODY;
          end
        end
        HDR: if (free) begin
          // After the last full header beat the residual bytes become the carry.
          hdr_sr <= hdr_next;
          carry  <= hdr_next[SR_WD-1 -: DATA_WD];
          beats  <= beats - 1'b1;
          if (beats == CNT_WD'(1)) state <= BODY;
        end
        BODY: if (in_hs) begin
          if (res != '0) carry <= data_in << {WB - res, 3'b000};
          if (last_in) begin
            if (fits) begin
              state   <= IDLE;
              ins_rdy <= 1'b1;
            end else begin
              state  <= TAIL;
              tail_n <= k_in - (WB - res);
            end
          end
        end
        TAIL: if (free) begin
          state   <= IDLE;
          ins_rdy <= 1'b1;
        end
      endcase
    end
  end

  axis_out_reg #(.DATA_WD(DATA_WD), .KEEP_WD(DATA_BYTE_WD)) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .push_keep (push_keep),
    .push_last (push_last),
    .free      (free),
    .valid     (valid_out),
    .data      (data_out),
    .keep      (keep_out),
    .last      (last_out),
    .ready     (ready_out)
  );

`ifdef AXIS_INS_STAT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_cnt  <= '0;
      byte_cnt <= '0;
    end else if (valid_out && ready_out) begin
      pkt_cnt  <= pkt_cnt + 32'(last_out);
      byte_cnt <= byte_cnt + 48'(popcnt(64'(keep_out)));
    end
  end
`endif

endmodule
